// File: rtl/bottling_ctrl.sv
// bottling_ctrl: pill-bottling sequencer with BCD pill/bottle counters,
// hopper-starvation and conveyor supervision, resume and emergency stop.
//   clk_1khz       system clock
//   switch_clr     async active-high reset
//   start          pulse: latch targets, begin batch (SETTING only)
//   resume         pulse: leave ERROR
//   ack            pulse: leave DONE/FATAL
//   emergency_stop level: force FATAL from RUNNING/SWITCHING/ERROR
//   hopper_level   raw pill sensor, rising edge = one pill
//   conveyor_ok    level, 1 = conveyor moving
//   target_pills   BCD pills per bottle
//   target_bottles BCD bottles per batch
//   state          0 SETTING 1 RUNNING 2 SWITCHING 3 DONE 4 ERROR 5 FATAL
//   now_pills      BCD pills in current bottle
//   now_bottles    BCD completed bottles
//   fault_code     0 none 1 starve 2 conveyor 3 overfill 4 emergency
//   hopper_gate    1 only in RUNNING
//   beep_mode      0 off 1 continuous 2 2Hz 3 4Hz
module bottling_ctrl #(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2,
    parameter int TICKS_PER_SEC = 1000,
    parameter int SWITCH_SEC    = 2,
    parameter int HOPPER_SEC    = 4
) (
    input  logic                       clk_1khz,
    input  logic                       switch_clr,
    input  logic                       start,
    input  logic                       resume,
    input  logic                       ack,
    input  logic                       emergency_stop,
    input  logic                       hopper_level,
    input  logic                       conveyor_ok,
    input  logic [4*PILL_DIGITS-1:0]   target_pills,
    input  logic [4*BOTTLE_DIGITS-1:0] target_bottles,
    output logic [2:0]                 state,
    output logic [4*PILL_DIGITS-1:0]   now_pills,
    output logic [4*BOTTLE_DIGITS-1:0] now_bottles,
    output logic [2:0]                 fault_code,
    output logic                       hopper_gate,
    output logic [1:0]                 beep_mode
);
    localparam int PW       = 4*PILL_DIGITS;
    localparam int BW       = 4*BOTTLE_DIGITS;
    localparam int HOP_LOAD = HOPPER_SEC*TICKS_PER_SEC - 1;
    localparam int SW_LOAD  = SWITCH_SEC*TICKS_PER_SEC - 1;
    localparam int HW       = $clog2(HOP_LOAD) + 1;
    localparam int SWW      = $clog2(SW_LOAD) + 1;
    localparam logic [HW-1:0]  HOP_LD = HW'(HOP_LOAD);
    localparam logic [SWW-1:0] SW_LD  = SWW'(SW_LOAD);
    localparam logic [2:0] F_NONE = 3'd0, F_STARVE = 3'd1, F_CONV = 3'd2, F_OVER = 3'd3, F_EMERG = 3'd4;

    typedef enum logic [2:0] {
        S_SETTING   = 3'd0,
        S_RUNNING   = 3'd1,
        S_SWITCHING = 3'd2,
        S_DONE      = 3'd3,
        S_ERROR     = 3'd4,
        S_FATAL     = 3'd5
    } state_t;

    state_t          r_state, w_state;
    logic [PW-1:0]   r_pills, w_pills, r_tgt_p, w_tgt_p, w_np;
    logic [BW-1:0]   r_bottles, w_bottles, r_tgt_b, w_tgt_b, w_nb;
    logic [2:0]      r_fault, w_fault;
    logic [HW-1:0]   r_hop_tmr, w_hop_tmr;
    logic [SWW-1:0]  r_sw_tmr, w_sw_tmr;
    logic            r_overfill, w_overfill, w_of;
    logic            r_hop_sync, r_hop_prev, w_pill, w_tgt_ok;
    logic            r_gate;
    logic [1:0]      r_beep, w_beep;

    function automatic logic [PW-1:0] inc_p(input logic [PW-1:0] v);
        logic c;
        inc_p = v;
        c = 1'b1;
        for (int i = 0; i < PILL_DIGITS; i++) begin
            if (c) begin
                inc_p[4*i+:4] = (v[4*i+:4] == 4'd9) ? 4'd0 : v[4*i+:4] + 4'd1;
                c = (v[4*i+:4] == 4'd9);
            end
        end
    endfunction

    function automatic logic [BW-1:0] inc_b(input logic [BW-1:0] v);
        logic c;
        inc_b = v;
        c = 1'b1;
        for (int i = 0; i < BOTTLE_DIGITS; i++) begin
            if (c) begin
                inc_b[4*i+:4] = (v[4*i+:4] == 4'd9) ? 4'd0 : v[4*i+:4] + 4'd1;
                c = (v[4*i+:4] == 4'd9);
            end
        end
    endfunction

    // The raw level is sampled once, then compared with the sample before it,
    // so a pill is counted one cycle after its rise is first sampled.
    assign w_pill = r_hop_sync & ~r_hop_prev;
    assign w_np   = inc_p(r_pills);
    assign w_nb   = inc_b(r_bottles);
    // A pill on the expiry cycle still counts as overfill.
    assign w_of   = r_overfill | w_pill;

    always_comb begin
        w_tgt_ok = (target_pills != '0) && (target_bottles != '0);
        for (int i = 0; i < PILL_DIGITS; i++)
            if (target_pills[4*i+:4] > 4'd9) w_tgt_ok = 1'b0;
        for (int i = 0; i < BOTTLE_DIGITS; i++)
            if (target_bottles[4*i+:4] > 4'd9) w_tgt_ok = 1'b0;
    end

    always_comb begin
        w_state    = r_state;
        w_pills    = r_pills;
        w_bottles  = r_bottles;
        w_fault    = r_fault;
        w_tgt_p    = r_tgt_p;
        w_tgt_b    = r_tgt_b;
        w_overfill = r_overfill;
        w_hop_tmr  = (r_hop_tmr != '0) ? r_hop_tmr - HW'(1) : '0;
        w_sw_tmr   = (r_sw_tmr != '0) ? r_sw_tmr - SWW'(1) : '0;
        case (r_state)
            S_SETTING: begin
                w_pills   = '0;
                w_bottles = '0;
                w_fault   = F_NONE;
                if (start && w_tgt_ok) begin
                    w_state   = S_RUNNING;
                    w_tgt_p   = target_pills;
                    w_tgt_b   = target_bottles;
                    w_hop_tmr = HOP_LD;
                end
            end
            S_RUNNING: begin
                if (emergency_stop) begin
                    w_state = S_FATAL;
                    w_fault = F_EMERG;
                end else if (w_pill) begin
                    w_pills   = w_np;
                    w_hop_tmr = HOP_LD;
                    if (w_np == r_tgt_p) begin
                        w_bottles  = w_nb;
                        w_state    = (w_nb == r_tgt_b) ? S_DONE : S_SWITCHING;
                        w_sw_tmr   = SW_LD;
                        w_overfill = 1'b0;
                    end
                end else if (r_hop_tmr == '0) begin
                    w_state = S_ERROR;
                    w_fault = F_STARVE;
                end
            end
            S_SWITCHING: begin
                if (emergency_stop) begin
                    w_state = S_FATAL;
                    w_fault = F_EMERG;
                end else begin
                    w_overfill = w_of;
                    if (r_sw_tmr == '0) begin
                        if (w_of) begin
                            w_state = S_FATAL;
                            w_fault = F_OVER;
                        end else if (conveyor_ok) begin
                            w_state   = S_RUNNING;
                            w_pills   = '0;
                            w_hop_tmr = HOP_LD;
                        end else begin
                            w_state = S_ERROR;
                            w_fault = F_CONV;
                        end
                    end
                end
            end
            S_ERROR: begin
                if (emergency_stop) begin
                    w_state = S_FATAL;
                    w_fault = F_EMERG;
                end else if (resume && (r_fault == F_STARVE || conveyor_ok)) begin
                    w_state   = S_RUNNING;
                    w_pills   = (r_fault == F_STARVE) ? r_pills : '0;
                    w_fault   = F_NONE;
                    w_hop_tmr = HOP_LD;
                end
            end
            S_DONE, S_FATAL: begin
                if (ack) begin
                    w_state   = S_SETTING;
                    w_pills   = '0;
                    w_bottles = '0;
                    w_fault   = F_NONE;
                end
            end
            default: w_state = S_SETTING;
        endcase
        w_beep = (w_state == S_FATAL) ? 2'd1 :
                 (w_state == S_DONE)  ? 2'd2 :
                 (w_state == S_ERROR) ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_state    <= S_SETTING;
            r_pills    <= '0;
            r_bottles  <= '0;
            r_fault    <= F_NONE;
            r_tgt_p    <= '0;
            r_tgt_b    <= '0;
            r_hop_tmr  <= '0;
            r_sw_tmr   <= '0;
            r_overfill <= 1'b0;
            r_hop_sync <= 1'b0;
            r_hop_prev <= 1'b0;
            r_gate     <= 1'b0;
            r_beep     <= 2'd0;
        end else begin
            r_state    <= w_state;
            r_pills    <= w_pills;
            r_bottles  <= w_bottles;
            r_fault    <= w_fault;
            r_tgt_p    <= w_tgt_p;
            r_tgt_b    <= w_tgt_b;
            r_hop_tmr  <= w_hop_tmr;
            r_sw_tmr   <= w_sw_tmr;
            r_overfill <= w_overfill;
            r_hop_sync <= hopper_level;
            r_hop_prev <= r_hop_sync;
            r_gate     <= (w_state == S_RUNNING);
            r_beep     <= w_beep;
        end
    end

    assign state       = r_state;
    assign now_pills   = r_pills;
    assign now_bottles = r_bottles;
    assign fault_code  = r_fault;
    assign hopper_gate = r_gate;
    assign beep_mode   = r_beep;
endmodule

// File: tb/tb_bottling_ctrl.sv
// tb_bottling_ctrl: scenario and randomized checks of bottling_ctrl against a behavioural model.
module tb_bottling_ctrl;
    localparam int PD = 3, BD = 2, TPS = 10, SWS = 2, HPS = 3;
    localparam int H = HPS*TPS, S = SWS*TPS;

    logic clk_1khz = 1'b0, switch_clr = 1'b0, start = 1'b0, resume = 1'b0, ack = 1'b0;
    logic emergency_stop = 1'b0, hopper_level = 1'b0, conveyor_ok = 1'b1;
    logic [4*PD-1:0] target_pills = '0;
    logic [4*BD-1:0] target_bottles = '0;
    logic [2:0] state, fault_code;
    logic [4*PD-1:0] now_pills;
    logic [4*BD-1:0] now_bottles;
    logic hopper_gate;
    logic [1:0] beep_mode;
    logic [28:0] obs;

    int vectors = 0, errors = 0;
    int m_state, m_pills, m_bottles, m_fault, m_tp, m_tb, m_cyc, m_hop_due, m_sw_due;
    bit m_of, h1, h2;

    bottling_ctrl #(.PILL_DIGITS(PD), .BOTTLE_DIGITS(BD), .TICKS_PER_SEC(TPS),
                    .SWITCH_SEC(SWS), .HOPPER_SEC(HPS)) dut (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .start(start), .resume(resume),
        .ack(ack), .emergency_stop(emergency_stop), .hopper_level(hopper_level),
        .conveyor_ok(conveyor_ok), .target_pills(target_pills), .target_bottles(target_bottles),
        .state(state), .now_pills(now_pills), .now_bottles(now_bottles), .fault_code(fault_code),
        .hopper_gate(hopper_gate), .beep_mode(beep_mode));

    always #5 clk_1khz = ~clk_1khz;
    assign obs = {state, now_pills, now_bottles, fault_code, hopper_gate, beep_mode};

    function automatic int bcd_val(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            if (v[4*i+:4] > 4'd9) return -1;
            r = r*10 + int'(v[4*i+:4]);
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int x);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [1:0] beep_of(input int st);
        return (st == 5) ? 2'd1 : (st == 3) ? 2'd2 : (st == 4) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [28:0] mk(input int st, input logic [11:0] p, input logic [7:0] b, input int f);
        return {st[2:0], p, b, f[2:0], st == 1, beep_of(st)};
    endfunction

    function automatic logic [28:0] expv();
        logic [15:0] p, b;
        p = to_bcd(m_pills);
        b = to_bcd(m_bottles);
        return mk(m_state, p[11:0], b[7:0], m_fault);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pills = 0; m_bottles = 0; m_fault = 0; m_tp = 0; m_tb = 0;
        m_cyc = 0; m_hop_due = 0; m_sw_due = 0; m_of = 0; h1 = 0; h2 = 0;
    endtask

    // One clock edge of the reference: deadlines are absolute cycle numbers.
    task automatic model_step();
        bit p;
        int vp, vb;
        if (switch_clr) begin model_reset(); return; end
        m_cyc++;
        p = h1 && !h2;
        h2 = h1;
        h1 = hopper_level;
        case (m_state)
            0: begin
                vp = bcd_val({4'h0, target_pills});
                vb = bcd_val({8'h0, target_bottles});
                if (start && vp > 0 && vb > 0) begin
                    m_tp = vp; m_tb = vb; m_state = 1; m_hop_due = m_cyc + H;
                end
            end
            1: if (emergency_stop) begin m_state = 5; m_fault = 4; end
               else if (p) begin
                   m_pills++;
                   m_hop_due = m_cyc + H;
                   if (m_pills == m_tp) begin
                       m_bottles++;
                       if (m_bottles == m_tb) m_state = 3;
                       else begin m_state = 2; m_sw_due = m_cyc + S; m_of = 0; end
                   end
               end else if (m_cyc == m_hop_due) begin m_state = 4; m_fault = 1; end
            2: if (emergency_stop) begin m_state = 5; m_fault = 4; end
               else begin
                   if (p) m_of = 1;
                   if (m_cyc == m_sw_due) begin
                       if (m_of) begin m_state = 5; m_fault = 3; end
                       else if (conveyor_ok) begin m_state = 1; m_pills = 0; m_hop_due = m_cyc + H; end
                       else begin m_state = 4; m_fault = 2; end
                   end
               end
            4: if (emergency_stop) begin m_state = 5; m_fault = 4; end
               else if (resume && (m_fault == 1 || conveyor_ok)) begin
                   if (m_fault == 2) m_pills = 0;
                   m_fault = 0; m_state = 1; m_hop_due = m_cyc + H;
               end
            3, 5: if (ack) begin m_state = 0; m_pills = 0; m_bottles = 0; m_fault = 0; end
            default: m_state = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        model_step();
        #1;
    endtask

    task automatic pill();
        hopper_level = 1'b1; tick();
        hopper_level = 1'b0; tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        {start, resume, ack, emergency_stop, hopper_level} = '0;
        conveyor_ok = 1'b1;
        switch_clr = 1'b1; tick(); switch_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] e;
        e = mk(0, 12'h000, 8'h00, 0);
        #1 switch_clr = 1'b1;
        #1;
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL reset_async: got %h want %h", obs, e); end
        tick();
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", obs, e); end
        switch_clr = 1'b0;
    endtask

    task automatic test_batch();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h02;
        pulse_start();
        e = mk(1, 12'h000, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_start: got %h want %h", obs, e); end
        repeat (3) pill();
        e = mk(2, 12'h003, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_switch: got %h want %h", obs, e); end
        repeat (S-1) tick();
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_switch_hold: got %h want %h", obs, e); end
        tick();
        e = mk(1, 12'h000, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_resume_run: got %h want %h", obs, e); end
        repeat (3) pill();
        e = mk(3, 12'h003, 8'h02, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_done: got %h want %h", obs, e); end
        ack = 1'b1; tick(); ack = 1'b0;
        e = mk(0, 12'h000, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL batch_ack: got %h want %h", obs, e); end
    endtask

    task automatic test_starve();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h02;
        pulse_start();
        pill();
        repeat (H-1) tick();
        e = mk(1, 12'h001, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL starve_before: got %h want %h", obs, e); end
        tick();
        e = mk(4, 12'h001, 8'h00, 1); vectors++;
        if (obs !== e) begin errors++; $display("FAIL starve_error: got %h want %h", obs, e); end
        resume = 1'b1; tick(); resume = 1'b0;
        e = mk(1, 12'h001, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL starve_resume: got %h want %h", obs, e); end
        repeat (H-2) tick();
        pill();
        e = mk(1, 12'h002, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL starve_pill_wins: got %h want %h", obs, e); end
    endtask

    task automatic test_conveyor();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h02; conveyor_ok = 1'b0;
        pulse_start();
        repeat (3) pill();
        repeat (S-1) tick();
        e = mk(2, 12'h003, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL conv_switching: got %h want %h", obs, e); end
        tick();
        e = mk(4, 12'h003, 8'h01, 2); vectors++;
        if (obs !== e) begin errors++; $display("FAIL conv_error: got %h want %h", obs, e); end
        resume = 1'b1; tick(); resume = 1'b0;
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL conv_resume_ignored: got %h want %h", obs, e); end
        conveyor_ok = 1'b1;
        resume = 1'b1; tick(); resume = 1'b0;
        e = mk(1, 12'h000, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL conv_resume: got %h want %h", obs, e); end
    endtask

    task automatic test_overfill();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h02;
        pulse_start();
        repeat (3) pill();
        pill();
        repeat (S-3) tick();
        e = mk(2, 12'h003, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL overfill_hold: got %h want %h", obs, e); end
        tick();
        e = mk(5, 12'h003, 8'h01, 3); vectors++;
        if (obs !== e) begin errors++; $display("FAIL overfill_fatal: got %h want %h", obs, e); end
        ack = 1'b1; tick(); ack = 1'b0;
        e = mk(0, 12'h000, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL overfill_ack: got %h want %h", obs, e); end
    endtask

    task automatic test_carry();
        logic [28:0] e;
        do_reset();
        e = mk(0, 12'h000, 8'h00, 0);
        target_bottles = 8'h02;
        target_pills = 12'h00A; pulse_start(); vectors++;
        if (obs !== e) begin errors++; $display("FAIL carry_bad_digit: got %h want %h", obs, e); end
        target_pills = 12'h000; pulse_start(); vectors++;
        if (obs !== e) begin errors++; $display("FAIL carry_zero_pills: got %h want %h", obs, e); end
        target_pills = 12'h010; target_bottles = 8'h00; pulse_start(); vectors++;
        if (obs !== e) begin errors++; $display("FAIL carry_zero_bottles: got %h want %h", obs, e); end
        target_bottles = 8'h02; pulse_start();
        target_pills = 12'h001;
        repeat (9) pill();
        e = mk(1, 12'h009, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL carry_nine: got %h want %h", obs, e); end
        pill();
        e = mk(2, 12'h010, 8'h01, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL carry_ten: got %h want %h", obs, e); end
    endtask

    task automatic test_estop();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h01;
        pulse_start();
        repeat (2) pill();
        hopper_level = 1'b1; tick();
        hopper_level = 1'b0; emergency_stop = 1'b1; tick(); emergency_stop = 1'b0;
        e = mk(5, 12'h002, 8'h00, 4); vectors++;
        if (obs !== e) begin errors++; $display("FAIL estop_fatal: got %h want %h", obs, e); end
        ack = 1'b1; tick(); ack = 1'b0;
        emergency_stop = 1'b1; tick(); emergency_stop = 1'b0;
        e = mk(0, 12'h000, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL estop_setting_ignored: got %h want %h", obs, e); end
    endtask

    task automatic test_async_reset();
        logic [28:0] e;
        do_reset();
        target_pills = 12'h003; target_bottles = 8'h02;
        pulse_start();
        repeat (2) pill();
        #3 switch_clr = 1'b1;
        #1;
        e = mk(0, 12'h000, 8'h00, 0); vectors++;
        if (obs !== e) begin errors++; $display("FAIL async_reset: got %h want %h", obs, e); end
        tick();
        switch_clr = 1'b0;
    endtask

    task automatic test_random();
        int rate;
        logic [28:0] e;
        do_reset();
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = $urandom_range(2, 40);
            if ($urandom_range(0, rate) == 0) hopper_level = ~hopper_level;
            conveyor_ok    = ($urandom_range(0, 7) != 0);
            start          = ($urandom_range(0, 19) == 0);
            resume         = ($urandom_range(0, 9) == 0);
            ack            = ($urandom_range(0, 14) == 0);
            emergency_stop = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) begin
                target_pills   = ($urandom_range(0, 7) == 0) ? 12'h00B : 12'($urandom_range(1, 5));
                target_bottles = 8'($urandom_range(0, 3));
            end
            tick();
            e = expv();
            vectors++;
            if (obs !== e) begin
                errors++;
                if (errors < 20) $display("FAIL random cycle %0d: got %h want %h", c, obs, e);
            end
        end
        {start, resume, ack, emergency_stop} = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_batch();
        test_starve();
        test_conveyor();
        test_overfill();
        test_carry();
        test_estop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
